// File: rtl/stopwatch_pkg.sv
// Shared types and helpers for the MM:SS.hh lap stopwatch.
// Latency: n/a (types, constants and a combinational sanitise function only).
// Backpressure: n/a.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Digit order matches the display word: {m10,m1,s10,s1,h10,h1}.
    typedef struct packed {
        logic [3:0] m10;
        logic [3:0] m1;
        logic [3:0] s10;
        logic [3:0] s1;
        logic [3:0] h10;
        logic [3:0] h1;
    } bcd_time_t;

    localparam logic [3:0] SEC_TENS_MAX = 4'd5;
    localparam logic [3:0] DIGIT_MAX    = 4'd9;

    localparam bcd_time_t BCD_ZERO           = 24'h00_00_00;
    localparam bcd_time_t BCD_ONE_HUNDREDTH  = 24'h00_00_01;

    function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] lim);
        return (d > lim) ? lim : d;
    endfunction

    // Force a user preset into a legal time: digits to 0..9, s10 to 0..5,
    // minutes to at most max_min.
    function automatic bcd_time_t sanitise(input bcd_time_t p, input int max_min);
        bcd_time_t r;
        int        mins;
        r.m10 = clamp_digit(p.m10, DIGIT_MAX);
        r.m1  = clamp_digit(p.m1,  DIGIT_MAX);
        r.s10 = clamp_digit(p.s10, SEC_TENS_MAX);
        r.s1  = clamp_digit(p.s1,  DIGIT_MAX);
        r.h10 = clamp_digit(p.h10, DIGIT_MAX);
        r.h1  = clamp_digit(p.h1,  DIGIT_MAX);
        mins  = int'(r.m10) * 10 + int'(r.m1);
        if (mins > max_min) begin
            r.m10 = 4'(max_min / 10);
            r.m1  = 4'(max_min % 10);
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_time_counter.sv
// BCD MM:SS.hh time register with load, increment (wrapping at MAX_MIN:59.99) and decrement.
// Latency: count updates on the clock edge after load/inc/dec; is_zero/wrap_next are combinational from the count.
// Backpressure: none; load has priority over inc, inc over dec.
//
// Ports: i_clk/i_rst_n (sync, active-low), i_load + i_load_val, i_inc, i_dec,
//        o_count (current time), o_is_zero (count is 00:00.00),
//        o_wrap_next (count is MAX_MIN:59.99, so the next inc wraps to zero).
module bcd_time_counter
    import stopwatch_pkg::*;
#(
    parameter int MAX_MIN = 99
) (
    input  logic      i_clk,
    input  logic      i_rst_n,
    input  logic      i_load,
    input  bcd_time_t i_load_val,
    input  logic      i_inc,
    input  logic      i_dec,
    output bcd_time_t o_count,
    output logic      o_is_zero,
    output logic      o_wrap_next
);

    localparam logic [3:0] MAX_M10 = 4'(MAX_MIN / 10);
    localparam logic [3:0] MAX_M1  = 4'(MAX_MIN % 10);

    bcd_time_t r_count;
    bcd_time_t w_inc_val;
    bcd_time_t w_dec_val;
    bcd_time_t w_next;

    assign o_count     = r_count;
    assign o_is_zero   = (r_count == BCD_ZERO);
    assign o_wrap_next = (r_count.m10 == MAX_M10) && (r_count.m1 == MAX_M1) &&
                         (r_count.s10 == SEC_TENS_MAX) && (r_count.s1 == DIGIT_MAX) &&
                         (r_count.h10 == DIGIT_MAX) && (r_count.h1 == DIGIT_MAX);

    // Carry cascade h1 -> h10 -> s1 -> s10 (0..5) -> m1 -> m10.
    always_comb begin
        w_inc_val = r_count;
        if (o_wrap_next) begin
            w_inc_val = BCD_ZERO;
        end else if (r_count.h1 != DIGIT_MAX) begin
            w_inc_val.h1 = r_count.h1 + 4'd1;
        end else begin
            w_inc_val.h1 = 4'd0;
            if (r_count.h10 != DIGIT_MAX) begin
                w_inc_val.h10 = r_count.h10 + 4'd1;
            end else begin
                w_inc_val.h10 = 4'd0;
                if (r_count.s1 != DIGIT_MAX) begin
                    w_inc_val.s1 = r_count.s1 + 4'd1;
                end else begin
                    w_inc_val.s1 = 4'd0;
                    if (r_count.s10 != SEC_TENS_MAX) begin
                        w_inc_val.s10 = r_count.s10 + 4'd1;
                    end else begin
                        w_inc_val.s10 = 4'd0;
                        if (r_count.m1 != DIGIT_MAX) begin
                            w_inc_val.m1 = r_count.m1 + 4'd1;
                        end else begin
                            w_inc_val.m1  = 4'd0;
                            w_inc_val.m10 = r_count.m10 + 4'd1;
                        end
                    end
                end
            end
        end
    end

    // Borrow cascade; a digit at 0 reloads its maximum and borrows upward.
    always_comb begin
        w_dec_val = r_count;
        if (r_count.h1 != 4'd0) begin
            w_dec_val.h1 = r_count.h1 - 4'd1;
        end else begin
            w_dec_val.h1 = DIGIT_MAX;
            if (r_count.h10 != 4'd0) begin
                w_dec_val.h10 = r_count.h10 - 4'd1;
            end else begin
                w_dec_val.h10 = DIGIT_MAX;
                if (r_count.s1 != 4'd0) begin
                    w_dec_val.s1 = r_count.s1 - 4'd1;
                end else begin
                    w_dec_val.s1 = DIGIT_MAX;
                    if (r_count.s10 != 4'd0) begin
                        w_dec_val.s10 = r_count.s10 - 4'd1;
                    end else begin
                        w_dec_val.s10 = SEC_TENS_MAX;
                        if (r_count.m1 != 4'd0) begin
                            w_dec_val.m1 = r_count.m1 - 4'd1;
                        end else begin
                            w_dec_val.m1  = DIGIT_MAX;
                            w_dec_val.m10 = r_count.m10 - 4'd1;
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        w_next = r_count;
        if (i_load) begin
            w_next = i_load_val;
        end else if (i_inc) begin
            w_next = w_inc_val;
        end else if (i_dec) begin
            w_next = w_dec_val;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_count <= BCD_ZERO;
        end else begin
            r_count <= w_next;
        end
    end

endmodule

// File: rtl/stopwatch_lap.sv
// Up/down BCD stopwatch (10 ms resolution) with a LAP_DEPTH-entry ring of lap times for recall.
// Latency: raw key fall to effect SYNC_STAGES+1 cycles; tick to count 1 cycle; count/recall to disp_bcd 1 cycle.
// Backpressure: none; each key yields one press pulse, clear beats start/lap in the same cycle.
//
// Ports: CLOCK_50, RST_N (sync, active-low); KEY_START_N/KEY_LAP_N/KEY_CLR_N raw active-low keys;
//        mode (0 up, 1 down) and preset (BCD countdown start), both taken on clear;
//        recall/recall_idx select a stored lap for display;
//        disp_bcd, running, done, wrapped, lap_count are registered outputs.
module stopwatch_lap
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ      = 50_000_000,
    parameter int MAX_MIN     = 99,
    parameter int LAP_DEPTH   = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         CLOCK_50,
    input  logic                         RST_N,
    input  logic                         KEY_START_N,
    input  logic                         KEY_LAP_N,
    input  logic                         KEY_CLR_N,
    input  logic                         mode,
    input  logic [23:0]                  preset,
    input  logic                         recall,
    input  logic [$clog2(LAP_DEPTH)-1:0] recall_idx,
    output logic [23:0]                  disp_bcd,
    output logic                         running,
    output logic                         done,
    output logic                         wrapped,
    output logic [$clog2(LAP_DEPTH):0]   lap_count
);

    localparam int DIV   = CLK_HZ / 100;
    localparam int DIV_W = $clog2(DIV);
    localparam int IDX_W = $clog2(LAP_DEPTH);

    // ---------------- key synchronisers and press detect ----------------
    // Index 0 = start, 1 = lap, 2 = clear. Flops reset to the released level
    // so leaving reset never looks like a press.
    logic [2:0]             w_keys_raw;
    logic [SYNC_STAGES-1:0] r_sync [3];
    logic [2:0]             r_key_prev;
    logic [2:0]             w_key_sync;
    logic [2:0]             w_press;
    logic                   w_start_p;
    logic                   w_lap_p;
    logic                   w_clr_p;

    assign w_keys_raw = {KEY_CLR_N, KEY_LAP_N, KEY_START_N};

    always_ff @(posedge CLOCK_50) begin
        if (!RST_N) begin
            for (int k = 0; k < 3; k++) begin
                r_sync[k] <= '1;
            end
            r_key_prev <= '1;
        end else begin
            for (int k = 0; k < 3; k++) begin
                r_sync[k]     <= {r_sync[k][SYNC_STAGES-2:0], w_keys_raw[k]};
                r_key_prev[k] <= r_sync[k][SYNC_STAGES-1];
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            w_key_sync[k] = r_sync[k][SYNC_STAGES-1];
        end
    end

    assign w_press   = r_key_prev & ~w_key_sync;
    assign w_clr_p   = w_press[2];
    assign w_start_p = w_press[0] & ~w_clr_p;
    assign w_lap_p   = w_press[1] & ~w_clr_p;

    // ---------------- state and 10 ms divider ----------------
    state_t           r_state;
    state_t           w_state_next;
    logic             r_mode_q;
    logic [DIV_W-1:0] r_div;
    logic             w_tick;

    assign w_tick = (r_state == ST_RUN) && (r_div == DIV_W'(DIV - 1));

    // The divider only advances in RUN, so a pause keeps the partial interval.
    always_ff @(posedge CLOCK_50) begin
        if (!RST_N) begin
            r_div <= '0;
        end else if (w_clr_p) begin
            r_div <= '0;
        end else if (r_state == ST_RUN) begin
            r_div <= w_tick ? '0 : r_div + DIV_W'(1);
        end
    end

    // ---------------- time counter ----------------
    bcd_time_t w_count;
    bcd_time_t w_load_val;
    logic      w_is_zero;
    logic      w_wrap_next;
    logic      w_inc;
    logic      w_dec;
    logic      w_hit_zero;

    always_comb begin
        w_load_val = BCD_ZERO;
        if (mode) begin
            w_load_val = sanitise(bcd_time_t'(preset), MAX_MIN);
        end
    end

    assign w_inc      = w_tick & ~r_mode_q;
    assign w_dec      = w_tick &  r_mode_q;
    // The count that this tick will turn into 00:00.00.
    assign w_hit_zero = w_dec && (w_count == BCD_ONE_HUNDREDTH);

    bcd_time_counter #(
        .MAX_MIN (MAX_MIN)
    ) u_counter (
        .i_clk       (CLOCK_50),
        .i_rst_n     (RST_N),
        .i_load      (w_clr_p),
        .i_load_val  (w_load_val),
        .i_inc       (w_inc),
        .i_dec       (w_dec),
        .o_count     (w_count),
        .o_is_zero   (w_is_zero),
        .o_wrap_next (w_wrap_next)
    );

    // ---------------- FSM ----------------
    always_ff @(posedge CLOCK_50) begin
        if (!RST_N) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_clr_p) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // A countdown from zero would finish instantly; refuse it.
                    if (w_start_p && !(r_mode_q && w_is_zero)) begin
                        w_state_next = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_hit_zero) begin
                        w_state_next = ST_DONE;
                    end else if (w_start_p) begin
                        w_state_next = ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    if (w_start_p) begin
                        w_state_next = ST_RUN;
                    end
                end
                ST_DONE: begin
                    w_state_next = ST_DONE;
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

    // Status flags are registered from the next state so they move with r_state.
    logic r_running;
    logic r_done;
    logic r_wrapped;

    always_ff @(posedge CLOCK_50) begin
        if (!RST_N) begin
            r_mode_q  <= 1'b0;
            r_running <= 1'b0;
            r_done    <= 1'b0;
            r_wrapped <= 1'b0;
        end else begin
            r_running <= (w_state_next == ST_RUN);
            r_done    <= (w_state_next == ST_DONE);
            if (w_clr_p) begin
                r_mode_q  <= mode;
                r_wrapped <= 1'b0;
            end else if (w_inc && w_wrap_next) begin
                r_wrapped <= 1'b1;
            end
        end
    end

    // ---------------- lap ring buffer ----------------
    bcd_time_t        r_lap [LAP_DEPTH];
    logic [IDX_W-1:0] r_wr_ptr;
    logic [IDX_W:0]   r_lap_count;
    logic             w_lap_wr;

    assign w_lap_wr = w_lap_p && (r_state == ST_RUN);

    // Stores the count as it stands before this edge, so a coincident tick
    // does not leak into the lap.
    always_ff @(posedge CLOCK_50) begin
        if (!RST_N || w_clr_p) begin
            for (int i = 0; i < LAP_DEPTH; i++) begin
                r_lap[i] <= BCD_ZERO;
            end
            r_wr_ptr    <= '0;
            r_lap_count <= '0;
        end else if (w_lap_wr) begin
            r_lap[r_wr_ptr] <= w_count;
            r_wr_ptr        <= r_wr_ptr + IDX_W'(1);
            if (r_lap_count != (IDX_W + 1)'(LAP_DEPTH)) begin
                r_lap_count <= r_lap_count + (IDX_W + 1)'(1);
            end
        end
    end

    // ---------------- display ----------------
    logic [23:0] r_disp;
    logic        w_recall_valid;

    assign w_recall_valid = ({1'b0, recall_idx} < r_lap_count);

    always_ff @(posedge CLOCK_50) begin
        if (!RST_N) begin
            r_disp <= '0;
        end else if (recall) begin
            r_disp <= w_recall_valid ? r_lap[recall_idx] : '0;
        end else begin
            r_disp <= w_count;
        end
    end

    assign disp_bcd  = r_disp;
    assign running   = r_running;
    assign done      = r_done;
    assign wrapped   = r_wrapped;
    assign lap_count = r_lap_count;

endmodule

// File: tb/tb_stopwatch_lap.sv
// Scoreboard bench for stopwatch_lap: main unit at DIV=10/MAX_MIN=99, second unit at DIV=2/MAX_MIN=1 for wrap/clamp.
// Stimulus pushes expected outputs, then raises a sample strobe; the monitor pops and compares on the falling edge.
// Keys are shared by both units; each key press is a one-cycle raw low pulse.
module tb_stopwatch_lap;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        key_start_n;
    logic        key_lap_n;
    logic        key_clr_n;
    logic        mode;
    logic [23:0] preset;
    logic        recall;
    logic [1:0]  recall_idx;

    logic [23:0] a_disp;
    logic        a_run;
    logic        a_done;
    logic        a_wrap;
    logic [2:0]  a_laps;
    logic [23:0] b_disp;
    logic        b_run;
    logic        b_done;
    logic        b_wrap;
    logic [2:0]  b_laps;

    stopwatch_lap #(
        .CLK_HZ      (1000),
        .MAX_MIN     (99),
        .LAP_DEPTH   (4),
        .SYNC_STAGES (2)
    ) u_dut (
        .CLOCK_50    (clk),
        .RST_N       (rst_n),
        .KEY_START_N (key_start_n),
        .KEY_LAP_N   (key_lap_n),
        .KEY_CLR_N   (key_clr_n),
        .mode        (mode),
        .preset      (preset),
        .recall      (recall),
        .recall_idx  (recall_idx),
        .disp_bcd    (a_disp),
        .running     (a_run),
        .done        (a_done),
        .wrapped     (a_wrap),
        .lap_count   (a_laps)
    );

    stopwatch_lap #(
        .CLK_HZ      (200),
        .MAX_MIN     (1),
        .LAP_DEPTH   (4),
        .SYNC_STAGES (2)
    ) u_wrap (
        .CLOCK_50    (clk),
        .RST_N       (rst_n),
        .KEY_START_N (key_start_n),
        .KEY_LAP_N   (key_lap_n),
        .KEY_CLR_N   (key_clr_n),
        .mode        (mode),
        .preset      (preset),
        .recall      (recall),
        .recall_idx  (recall_idx),
        .disp_bcd    (b_disp),
        .running     (b_run),
        .done        (b_done),
        .wrapped     (b_wrap),
        .lap_count   (b_laps)
    );

    typedef struct {
        string       name;
        int          unit_sel;
        logic [29:0] want;
    } exp_t;

    exp_t sb_q[$];
    logic chk_req = 1'b0;
    int   total   = 0;
    int   bad     = 0;

    // ---------------- monitor ----------------
    always @(negedge clk) begin : monitor
        exp_t        e;
        logic [29:0] act;
        if (chk_req) begin
            while (sb_q.size() > 0) begin
                e   = sb_q.pop_front();
                act = (e.unit_sel == 0) ? {a_disp, a_run, a_done, a_wrap, a_laps}
                                        : {b_disp, b_run, b_done, b_wrap, b_laps};
                total++;
                if (act !== e.want) begin
                    bad++;
                    $display("FAIL %s (unit %0d): got disp=%h run=%b done=%b wrap=%b laps=%0d, want disp=%h run=%b done=%b wrap=%b laps=%0d",
                             e.name, e.unit_sel, act[29:6], act[5], act[4], act[3], act[2:0],
                             e.want[29:6], e.want[5], e.want[4], e.want[3], e.want[2:0]);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic expect_out(input string name, input int u, input logic [23:0] d,
                              input logic r, input logic dn, input logic w, input logic [2:0] l);
        exp_t e;
        e.name     = name;
        e.unit_sel = u;
        e.want     = {d, r, dn, w, l};
        sb_q.push_back(e);
    endtask

    task automatic sample();
        chk_req = 1'b1;
        @(negedge clk);
        #1;
        chk_req = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One-cycle raw low pulse; returns just after the edge where the press takes effect.
    task automatic press(input logic s, input logic l, input logic c);
        key_start_n = ~s;
        key_lap_n   = ~l;
        key_clr_n   = ~c;
        wait_cyc(1);
        key_start_n = 1'b1;
        key_lap_n   = 1'b1;
        key_clr_n   = 1'b1;
        wait_cyc(2);
    endtask

    initial begin : timeout
        #2_000_000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1, "timeout");
    end

    // ---------------- directed sequence ----------------
    initial begin : stim
        logic [23:0] lap_exp [4];
        lap_exp[0] = 24'h000005;
        lap_exp[1] = 24'h000002;
        lap_exp[2] = 24'h000003;
        lap_exp[3] = 24'h000004;

        rst_n       = 1'b0;
        key_start_n = 1'b1;
        key_lap_n   = 1'b1;
        key_clr_n   = 1'b1;
        mode        = 1'b0;
        preset      = 24'h0;
        recall      = 1'b0;
        recall_idx  = 2'd0;
        wait_cyc(3);
        expect_out("reset_main", 0, 24'h0, 0, 0, 0, 0);
        expect_out("reset_wrap", 1, 24'h0, 0, 0, 0, 0);
        sample();
        rst_n = 1'b1;
        wait_cyc(2);

        // Up count: 100 ticks of 10 cycles each.
        press(0, 0, 1);
        press(1, 0, 0);
        expect_out("start_run", 0, 24'h000000, 1, 0, 0, 0);
        sample();
        wait_cyc(1001);
        expect_out("up_100_ticks", 0, 24'h000100, 1, 0, 0, 0);
        sample();
        press(1, 0, 0);
        press(0, 1, 0);
        expect_out("lap_in_pause", 0, 24'h000100, 0, 0, 0, 0);
        sample();
        recall     = 1'b1;
        recall_idx = 2'd0;
        wait_cyc(1);
        expect_out("recall_empty", 0, 24'h000000, 0, 0, 0, 0);
        sample();
        recall = 1'b0;
        wait_cyc(1);
        expect_out("recall_off", 0, 24'h000100, 0, 0, 0, 0);
        sample();
        // Pause left the divider at 4, so the next tick lands 6 cycles after resume.
        press(1, 0, 0);
        wait_cyc(6);
        expect_out("resume_hold", 0, 24'h000100, 1, 0, 0, 0);
        sample();
        wait_cyc(1);
        expect_out("resume_tick", 0, 24'h000101, 1, 0, 0, 0);
        sample();

        // Five laps at counts 1..5; the fifth overwrites entry 0.
        press(0, 0, 1);
        press(1, 0, 0);
        wait_cyc(12);
        press(0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            wait_cyc(7);
            press(0, 1, 0);
        end
        press(1, 0, 0);
        expect_out("laps_saturate", 0, 24'h000005, 0, 0, 0, 3'd4);
        sample();
        recall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            recall_idx = 2'(i);
            wait_cyc(1);
            expect_out($sformatf("lap_recall_%0d", i), 0, lap_exp[i], 0, 0, 0, 3'd4);
            sample();
        end
        recall = 1'b0;

        // Countdown from 00:00.03.
        mode   = 1'b1;
        preset = 24'h000003;
        press(0, 0, 1);
        wait_cyc(1);
        expect_out("down_load", 0, 24'h000003, 0, 0, 0, 0);
        sample();
        press(1, 0, 0);
        wait_cyc(29);
        expect_out("down_one", 0, 24'h000001, 1, 0, 0, 0);
        sample();
        wait_cyc(2);
        expect_out("down_done", 0, 24'h000000, 0, 1, 0, 0);
        sample();
        press(1, 0, 0);
        expect_out("done_ignores_start", 0, 24'h000000, 0, 1, 0, 0);
        sample();
        press(0, 0, 1);
        wait_cyc(1);
        expect_out("done_clear_reload", 0, 24'h000003, 0, 0, 0, 0);
        sample();

        // Start and clear together while running.
        press(1, 0, 0);
        wait_cyc(12);
        expect_out("down_running", 0, 24'h000002, 1, 0, 0, 0);
        sample();
        press(1, 0, 1);
        wait_cyc(1);
        expect_out("start_clear_reload", 0, 24'h000003, 0, 0, 0, 0);
        sample();

        // Countdown from zero refuses to start.
        preset = 24'h000000;
        press(0, 0, 1);
        press(1, 0, 0);
        wait_cyc(1);
        expect_out("down_zero_no_start", 0, 24'h000000, 0, 0, 0, 0);
        sample();

        // Preset sanitising, including minute clamp on the MAX_MIN=1 unit.
        preset = 24'h9A7999;
        press(0, 0, 1);
        wait_cyc(1);
        expect_out("preset_sanitise", 0, 24'h995999, 0, 0, 0, 0);
        expect_out("preset_min_clamp", 1, 24'h015999, 0, 0, 0, 0);
        sample();

        // Reset while running.
        press(1, 0, 0);
        wait_cyc(20);
        expect_out("pre_reset_run", 0, 24'h995998, 1, 0, 0, 0);
        sample();
        rst_n = 1'b0;
        wait_cyc(1);
        expect_out("midrun_reset_main", 0, 24'h0, 0, 0, 0, 0);
        expect_out("midrun_reset_wrap", 1, 24'h0, 0, 0, 0, 0);
        sample();
        rst_n = 1'b1;
        mode  = 1'b0;
        wait_cyc(2);

        // Up-count wrap on the MAX_MIN=1 unit (tick every 2 cycles).
        press(1, 0, 0);
        wait_cyc(23999);
        expect_out("wrap_before", 1, 24'h015999, 1, 0, 0, 0);
        sample();
        wait_cyc(2);
        expect_out("wrap_after", 1, 24'h000000, 1, 0, 1, 0);
        sample();

        if (b_wrap !== 1'b1 || b_run !== 1'b1) begin
            bad++;
            $display("FAIL wrap_direct: wrap=%b run=%b", b_wrap, b_run);
        end
        if (b_disp !== 24'h000000) begin
            bad++;
            $display("FAIL wrap_disp_direct: disp=%h", b_disp);
        end
        if (total < 28) begin
            bad++;
            $display("FAIL check_count: only %0d comparisons performed", total);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        if (bad == 0) begin
            $display("PASS");
        end else begin
            $display("FAIL %0d mismatches", bad);
        end
        $finish;
    end

endmodule
